// File: rtl/dispatch_queue_pkg.sv
// Shared types for the decode-to-dispatch queue: decoded payload, reorder tag and stored entry.
package dispatch_queue_pkg;

  localparam int DQ_TAG_BITS = 4;

  typedef logic [DQ_TAG_BITS-1:0] tag_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] imm;
  } decode_result_t;

  typedef struct packed {
    decode_result_t data;
    tag_t           tag;
  } dq_entry_t;

endpackage

// File: rtl/dq_group_tagger.sv
// Combinational per-lane tag assignment and valid-lane count for one decode group.
module dq_group_tagger
  import dispatch_queue_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int TAG_BITS = DQ_TAG_BITS,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]    in_valid,
  input  logic [TAG_BITS-1:0] next_tag,
  output logic [TAG_BITS-1:0] lane_tag [WIDTH],
  output logic [CW-1:0]       count
);

  // NOTE: every output gets a value before the loop touches it, so no latch can be inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_tag[i] = next_tag + TAG_BITS'(i);
      count       = count + CW'(in_valid[i]);
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order N-lane dispatch queue with sequential reorder tags, back-pressure and flush with tag rewind.
// Optional same-cycle bypass when empty: define DISPATCH_QUEUE_BYPASS_EN.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int DEPTH    = 8,
  parameter  int TAG_BITS = DQ_TAG_BITS,
  localparam int CW       = $clog2(WIDTH + 1),
  localparam int OW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_valid,
  input  decode_result_t       in_data   [WIDTH],
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_valid,
  output decode_result_t       out_data  [WIDTH],
  output tag_t                 out_tag   [WIDTH],
  input  logic [CW-1:0]        deq_count,
  input  logic                 flush,
  input  tag_t                 flush_tag,
  output logic [OW-1:0]        occupancy
);

  logic [OW-1:0]       occ_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [TAG_BITS-1:0] next_tag_q;
  dq_entry_t           mem_q [DEPTH];

  logic [TAG_BITS-1:0] lane_tag [WIDTH];
  logic [CW-1:0]       grp_count;
  logic                enq;
  logic [CW-1:0]       enq_count;

  dq_group_tagger #(
    .WIDTH    (WIDTH),
    .TAG_BITS (TAG_BITS)
  ) u_tagger (
    .in_valid (in_valid),
    .next_tag (next_tag_q),
    .lane_tag (lane_tag),
    .count    (grp_count)
  );

  // Readiness looks only at registered occupancy; a same-cycle dequeue earns no credit.
  assign in_ready  = occ_q <= OW'(DEPTH - WIDTH);
  assign enq       = in_ready && in_valid[0];
  assign enq_count = enq ? grp_count : '0;
  assign occupancy = occ_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      next_tag_q <= '0;
    end else if (flush) begin
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      next_tag_q <= flush_tag;
    end else begin
      occ_q      <= occ_q + OW'(enq_count) - OW'(deq_count);
      rd_ptr_q   <= rd_ptr_q + PW'(deq_count);
      wr_ptr_q   <= wr_ptr_q + PW'(enq_count);
      next_tag_q <= next_tag_q + TAG_BITS'(enq_count);
    end
  end

  // NOTE: payload storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_valid[i]) begin
          mem_q[wr_ptr_q + PW'(i)] <= '{data: in_data[i], tag: lane_tag[i]};
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = OW'(i) < occ_q;
      out_data[i]  = mem_q[rd_ptr_q + PW'(i)].data;
      out_tag[i]   = mem_q[rd_ptr_q + PW'(i)].tag;
    end
`ifdef DISPATCH_QUEUE_BYPASS_EN
    // Empty queue forwards the incoming group; storage is still written at wr_ptr == rd_ptr.
    if (occ_q == '0 && !flush) begin
      out_valid = in_valid;
      for (int i = 0; i < WIDTH; i++) begin
        out_data[i] = in_data[i];
        out_tag[i]  = lane_tag[i];
      end
    end
`endif
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: queue-based reference model plus directed literal checks.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     in_valid;
  decode_result_t in_data   [WIDTH];
  logic           in_ready;
  logic [1:0]     out_valid;
  decode_result_t out_data  [WIDTH];
  tag_t           out_tag   [WIDTH];
  logic [1:0]     deq_count;
  logic           flush;
  tag_t           flush_tag;
  logic [3:0]     occupancy;

  always #5 clk = ~clk;

  dispatch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .deq_count (deq_count),
    .flush     (flush),
    .flush_tag (flush_tag),
    .occupancy (occupancy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a plain FIFO of (payload, tag) plus the next tag to hand out.
  decode_result_t mq_data [$];
  tag_t           mq_tag  [$];
  int             m_tag;
  tag_t           deq_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit bypass_active(input logic [1:0] v, input logic fl);
`ifdef DISPATCH_QUEUE_BYPASS_EN
    return mq_data.size() == 0 && !fl && v[0];
`else
    return 1'b0 && (v[0] || fl);
`endif
  endfunction

  function automatic int present_count(input logic [1:0] v, input logic fl);
    if (bypass_active(v, fl)) return v[1] ? 2 : 1;
    return mq_data.size() < WIDTH ? mq_data.size() : WIDTH;
  endfunction

  task automatic compare_model();
    int  n;
    bit  byp;
    bit  exp_v;
    n   = mq_data.size();
    byp = bypass_active(in_valid, flush);
    check("in_ready", in_ready, (DEPTH - n) >= WIDTH);
    check("occupancy", occupancy, n);
    for (int i = 0; i < WIDTH; i++) begin
      exp_v = byp ? in_valid[i] : (i < n);
      check($sformatf("out_valid[%0d]", i), out_valid[i], exp_v);
      if (exp_v) begin
        if (byp) begin
          check($sformatf("out_data[%0d]", i), out_data[i], in_data[i]);
          check($sformatf("out_tag[%0d]", i), out_tag[i], tag_t'((m_tag + i) % 16));
        end else begin
          check($sformatf("out_data[%0d]", i), out_data[i], mq_data[i]);
          check($sformatf("out_tag[%0d]", i), out_tag[i], mq_tag[i]);
        end
      end
    end
  endtask

  task automatic update_model();
    int n;
    n = mq_data.size();
    if (flush) begin
      mq_data.delete();
      mq_tag.delete();
      m_tag = int'(flush_tag);
    end else begin
      if ((DEPTH - n) >= WIDTH && in_valid[0]) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (in_valid[i]) begin
            mq_data.push_back(in_data[i]);
            mq_tag.push_back(tag_t'(m_tag));
            m_tag = (m_tag + 1) % 16;
          end
        end
      end
      repeat (int'(deq_count)) begin
        void'(mq_data.pop_front());
        void'(mq_tag.pop_front());
      end
    end
  endtask

  task automatic drive(input logic [1:0] v, input decode_result_t d0, input decode_result_t d1,
                       input logic [1:0] deq, input logic fl, input tag_t ft);
    @(negedge clk);
    in_valid   = v;
    in_data[0] = d0;
    in_data[1] = d1;
    deq_count  = deq;
    flush      = fl;
    flush_tag  = ft;
    #1;
    compare_model();
    for (int i = 0; i < int'(deq); i++) deq_log.push_back(out_tag[i]);
  endtask

  task automatic finish_cycle();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [1:0] v, input logic [1:0] deq);
    drive(v, decode_result_t'($urandom), decode_result_t'($urandom), deq, 1'b0, '0);
    finish_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = '0;
    deq_count = '0;
    flush     = 1'b0;
    #1;
    check("reset occupancy", occupancy, 0);
    check("reset out_valid", out_valid, 2'b00);
    check("reset in_ready", in_ready, 1'b1);
    mq_data.delete();
    mq_tag.delete();
    deq_log.delete();
    m_tag = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] v;
    logic       fl;
    rst        = 1'b1;
    in_valid   = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    deq_count  = '0;
    flush      = 1'b0;
    flush_tag  = '0;
    m_tag      = 0;

    // First group lands with tags 0,1.
    do_reset();
    drive(2'b11, decode_result_t'(32'hA), decode_result_t'(32'hB), 2'd0, 1'b0, '0);
    finish_cycle();
    check("t1 out_valid", out_valid, 2'b11);
    check("t1 tag0", out_tag[0], 4'h0);
    check("t1 tag1", out_tag[1], 4'h1);
    check("t1 data0", out_data[0], 32'hA);
    check("t1 occupancy", occupancy, 2);

    // Fill to full, reject a fifth group, then drain back past the threshold.
    do_reset();
    repeat (4) cycle(2'b11, 2'd0);
    check("t2 full occupancy", occupancy, 8);
    check("t2 full in_ready", in_ready, 1'b0);
    cycle(2'b11, 2'd0);
    check("t2 rejected occupancy", occupancy, 8);
    cycle(2'b00, 2'd1);
    check("t2 occ after deq1", occupancy, 7);
    check("t2 in_ready after deq1", in_ready, 1'b0);
    cycle(2'b00, 2'd2);
    check("t2 occ after deq2", occupancy, 5);
    check("t2 in_ready after deq2", in_ready, 1'b1);

    // Steady stream through tag wrap.
    do_reset();
    for (int g = 0; g < 9; g++) begin
      cycle(2'b11, (g == 0) ? 2'd0 : 2'd2);
      check("t3 steady occupancy", occupancy, 2);
    end
    cycle(2'b00, 2'd2);
    check("t3 dequeued count", deq_log.size(), 18);
    for (int j = 0; j < 18 && j < deq_log.size(); j++)
      check($sformatf("t3 tag order %0d", j), deq_log[j], j % 16);

    // Single-lane groups pack into a contiguous prefix.
    do_reset();
    repeat (3) cycle(2'b01, 2'd0);
    check("t4 occupancy", occupancy, 3);
    check("t4 out_valid", out_valid, 2'b11);
    check("t4 tag0", out_tag[0], 4'h0);
    check("t4 tag1", out_tag[1], 4'h1);
    cycle(2'b00, 2'd2);
    check("t4 out_valid after deq", out_valid, 2'b01);
    check("t4 tag0 after deq", out_tag[0], 4'h2);

    // Flush beats a simultaneous enqueue and rewinds the tag.
    do_reset();
    cycle(2'b11, 2'd0);
    cycle(2'b11, 2'd0);
    cycle(2'b01, 2'd0);
    check("t5 occupancy before flush", occupancy, 5);
    drive(2'b11, decode_result_t'($urandom), decode_result_t'($urandom), 2'd0, 1'b1, 4'h9);
    finish_cycle();
    check("t5 occupancy after flush", occupancy, 0);
    check("t5 out_valid after flush", out_valid, 2'b00);
    cycle(2'b11, 2'd0);
    check("t5 tag0", out_tag[0], 4'h9);
    check("t5 tag1", out_tag[1], 4'hA);
    check("t5 out_valid", out_valid, 2'b11);

`ifdef DISPATCH_QUEUE_BYPASS_EN
    // Empty queue: group is visible and partly consumed in the same cycle.
    do_reset();
    drive(2'b11, decode_result_t'(32'hA), decode_result_t'(32'hB), 2'd1, 1'b0, '0);
    check("t6 bypass out_valid", out_valid, 2'b11);
    check("t6 bypass tag0", out_tag[0], 4'h0);
    check("t6 bypass tag1", out_tag[1], 4'h1);
    finish_cycle();
    check("t6 lane0 data", out_data[0], 32'hB);
    check("t6 lane0 tag", out_tag[0], 4'h1);
    check("t6 occupancy", occupancy, 1);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 2))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      fl = ($urandom_range(0, 19) == 0);
      drive(v, decode_result_t'($urandom), decode_result_t'($urandom),
            2'($urandom_range(0, present_count(v, fl))), fl, tag_t'($urandom));
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
